// File: rtl/laser_search_ctrl_pkg.sv
// laser_pkg: shared constants and types for the LASER two-circle search.
//   NPTS    - points per image
//   R2      - squared coverage radius (radius 4)
//   coord_t - 4-bit grid coordinate
//   cnt_t   - 6-bit coverage count (0..NPTS)
//   state_t - controller states
package laser_pkg;
    localparam int NPTS = 40;
    localparam int R2   = 16;

    typedef logic [3:0] coord_t;
    typedef logic [5:0] cnt_t;

    typedef enum logic [2:0] {LOAD, SCAN1, SCAN2, CHECK, FIN} state_t;
endpackage

// File: rtl/laser_search_ctrl_if.sv
// laser_search_ctrl_if: point-memory write port and coverage-evaluator
// request/ack handshake between the search controller and the evaluator.
//   PT_WE/PT_ADDR/PT_X/PT_Y      - point memory write (controller -> evaluator)
//   EV_REQ/EV_CX/EV_CY/EV_OX/EV_OY - candidate centre and fixed other centre
//   EV_ACK/EV_CNT                - evaluator done, union count valid with ack
// master: controller side; slave: evaluator side.
interface laser_search_ctrl_if;
    import laser_pkg::*;

    logic       PT_WE;
    logic [5:0] PT_ADDR;
    coord_t     PT_X;
    coord_t     PT_Y;
    logic       EV_REQ;
    coord_t     EV_CX;
    coord_t     EV_CY;
    coord_t     EV_OX;
    coord_t     EV_OY;
    logic       EV_ACK;
    cnt_t       EV_CNT;

    modport master (
        output PT_WE, PT_ADDR, PT_X, PT_Y,
        output EV_REQ, EV_CX, EV_CY, EV_OX, EV_OY,
        input  EV_ACK, EV_CNT
    );

    modport slave (
        input  PT_WE, PT_ADDR, PT_X, PT_Y,
        input  EV_REQ, EV_CX, EV_CY, EV_OX, EV_OY,
        output EV_ACK, EV_CNT
    );
endinterface

// File: rtl/laser_search_ctrl_scan_iter.sv
// laser_scan_iter: 8-bit candidate counter plus best-count tracker.
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   clr_scan_i     - restart candidate at 0, forget this scan's improvement
//   clr_best_i     - best count back to 0 (new image)
//   clr_imp_i      - clear the per-pass improvement flag
//   ack_i, cnt_i   - accepted evaluator result for the current candidate
//   cand_o/last_o  - current candidate, candidate is 255
//   pos_nx_o       - best position including a result accepted this cycle
//   simp_nx_o      - scan improved, including a result accepted this cycle
//   imp_o          - pass improved
module laser_scan_iter
    import laser_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_scan_i,
    input  logic       clr_best_i,
    input  logic       clr_imp_i,
    input  logic       ack_i,
    input  cnt_t       cnt_i,
    output logic [7:0] cand_o,
    output logic       last_o,
    output logic [7:0] pos_nx_o,
    output logic       simp_nx_o,
    output logic       imp_o
);
    logic [7:0] cand_q, pos_q;
    cnt_t       best_q;
    logic       imp_q, simp_q;
    logic       better;

    // Strict compare: ties keep the earlier candidate.
    assign better    = ack_i && (cnt_i > best_q);
    assign cand_o    = cand_q;
    assign last_o    = (cand_q == 8'hFF);
    assign pos_nx_o  = better ? cand_q : pos_q;
    assign simp_nx_o = simp_q | better;
    assign imp_o     = imp_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cand_q <= '0;
            pos_q  <= '0;
            best_q <= '0;
            imp_q  <= 1'b0;
            simp_q <= 1'b0;
        end else begin
            if (clr_best_i)  best_q <= '0;
            else if (better) best_q <= cnt_i;

            if (clr_imp_i)   imp_q <= 1'b0;
            else if (better) imp_q <= 1'b1;

            // Clear wins over ack so the last ack of SCAN1 restarts SCAN2 cleanly.
            if (clr_scan_i) begin
                cand_q <= '0;
                simp_q <= 1'b0;
            end else if (ack_i) begin
                cand_q <= cand_q + 8'd1;
                if (better) begin
                    pos_q  <= cand_q;
                    simp_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/laser_search_ctrl.sv
// laser_search_ctrl: loads a 40-point image into the evaluator's point memory,
// then alternates exhaustive 256-candidate scans of C1 (C2 fixed) and C2
// (C1 fixed), one evaluator request per candidate, until a pass brings no
// improvement or MAX_PASS passes are done. Publishes C1/C2 and pulses DONE.
//   CLK, RST           - clock, synchronous active-low reset
//   X, Y               - one point per LOAD cycle
//   bus (master)       - point-memory write and evaluator handshake
//   C1X/C1Y/C2X/C2Y    - published centres (updated at scan ends only)
//   DONE               - one-cycle result pulse
// Build option: LASER_FULL_EXIT_EN - an ack with count NPTS ends the search
// at once with the scanned centre set to that candidate.
module laser_search_ctrl #(
    parameter int NPTS     = laser_pkg::NPTS,
    parameter int MAX_PASS = 4,
    parameter int INIT_X   = 8,
    parameter int INIT_Y   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          X,
    input  logic [3:0]          Y,
    laser_search_ctrl_if.master bus,
    output logic [3:0]          C1X,
    output logic [3:0]          C1Y,
    output logic [3:0]          C2X,
    output logic [3:0]          C2Y,
    output logic                DONE
);
    import laser_pkg::*;

    localparam int PW = $clog2(MAX_PASS + 1);

    state_t        state_q, state_d;
    cnt_t          ld_cnt_q, ld_cnt_d;
    logic [PW-1:0] pass_q, pass_d;
    // Working centres; the published C outputs copy them at scan ends.
    coord_t        c1x_q, c1y_q, c2x_q, c2y_q;
    coord_t        c1x_d, c1y_d, c2x_d, c2y_d;
    logic          pub;

    logic          ev_req, ack, full_hit;
    logic          clr_scan, clr_best, clr_imp;
    logic [7:0]    cand, pos_nx;
    logic          last, simp_nx, imp;

    assign ev_req = (state_q == SCAN1) || (state_q == SCAN2);
    assign ack    = bus.EV_ACK && ev_req;
    assign DONE   = (state_q == FIN);

`ifdef LASER_FULL_EXIT_EN
    assign full_hit = ack && (bus.EV_CNT == cnt_t'(NPTS));
`else
    assign full_hit = 1'b0;
`endif

    assign bus.PT_WE   = (state_q == LOAD);
    assign bus.PT_ADDR = ld_cnt_q;
    assign bus.PT_X    = X;
    assign bus.PT_Y    = Y;
    assign bus.EV_REQ  = ev_req;
    assign bus.EV_CX   = cand[3:0];
    assign bus.EV_CY   = cand[7:4];
    assign bus.EV_OX   = (state_q == SCAN2) ? c1x_q : c2x_q;
    assign bus.EV_OY   = (state_q == SCAN2) ? c1y_q : c2y_q;

    laser_scan_iter u_iter (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .clr_scan_i (clr_scan),
        .clr_best_i (clr_best),
        .clr_imp_i  (clr_imp),
        .ack_i      (ack),
        .cnt_i      (bus.EV_CNT),
        .cand_o     (cand),
        .last_o     (last),
        .pos_nx_o   (pos_nx),
        .simp_nx_o  (simp_nx),
        .imp_o      (imp)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= LOAD;
            ld_cnt_q <= '0;
            pass_q   <= '0;
            c1x_q    <= '0;
            c1y_q    <= '0;
            c2x_q    <= '0;
            c2y_q    <= '0;
            C1X      <= '0;
            C1Y      <= '0;
            C2X      <= '0;
            C2Y      <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            pass_q   <= pass_d;
            c1x_q    <= c1x_d;
            c1y_q    <= c1y_d;
            c2x_q    <= c2x_d;
            c2y_q    <= c2y_d;
            if (pub) begin
                C1X <= c1x_d;
                C1Y <= c1y_d;
                C2X <= c2x_d;
                C2Y <= c2y_d;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        pass_d   = pass_q;
        c1x_d    = c1x_q;
        c1y_d    = c1y_q;
        c2x_d    = c2x_q;
        c2y_d    = c2y_q;
        pub      = 1'b0;
        clr_scan = 1'b0;
        clr_best = 1'b0;
        clr_imp  = 1'b0;
        case (state_q)
            LOAD: begin
                ld_cnt_d = ld_cnt_q + 6'd1;
                if (ld_cnt_q == cnt_t'(NPTS - 1)) begin
                    ld_cnt_d = '0;
                    pass_d   = '0;
                    clr_scan = 1'b1;
                    clr_best = 1'b1;
                    clr_imp  = 1'b1;
                    c1x_d    = '0;
                    c1y_d    = '0;
                    c2x_d    = coord_t'(INIT_X);
                    c2y_d    = coord_t'(INIT_Y);
                    state_d  = SCAN1;
                end
            end
            SCAN1: begin
                if (full_hit) begin
                    c1x_d   = cand[3:0];
                    c1y_d   = cand[7:4];
                    pub     = 1'b1;
                    state_d = FIN;
                end else if (ack && last) begin
                    if (simp_nx) begin
                        c1x_d = pos_nx[3:0];
                        c1y_d = pos_nx[7:4];
                    end
                    pub      = 1'b1;
                    clr_scan = 1'b1;
                    state_d  = SCAN2;
                end
            end
            SCAN2: begin
                if (full_hit) begin
                    c2x_d   = cand[3:0];
                    c2y_d   = cand[7:4];
                    pub     = 1'b1;
                    state_d = FIN;
                end else if (ack && last) begin
                    if (simp_nx) begin
                        c2x_d = pos_nx[3:0];
                        c2y_d = pos_nx[7:4];
                    end
                    pub     = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                pass_d = pass_q + PW'(1);
                if (!imp || (int'(pass_q) + 1 == MAX_PASS)) begin
                    state_d = FIN;
                end else begin
                    clr_imp  = 1'b1;
                    clr_scan = 1'b1;
                    state_d  = SCAN1;
                end
            end
            FIN: begin
                ld_cnt_d = '0;
                state_d  = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end
endmodule

// File: tb/tb_laser_search_ctrl.sv
module tb_laser_search_ctrl;
    import laser_pkg::*;

    localparam int MAX_PASS = 4;
    localparam int INIT_X   = 8;
    localparam int INIT_Y   = 8;
`ifdef LASER_FULL_EXIT_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif

    typedef int img_t [NPTS];

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] X = '0, Y = '0;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       DONE;

    laser_search_ctrl_if bus();

    laser_search_ctrl #(.NPTS(NPTS), .MAX_PASS(MAX_PASS), .INIT_X(INIT_X), .INIT_Y(INIT_Y)) dut (
        .CLK(CLK), .RST(RST), .X(X), .Y(Y), .bus(bus),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    img_t px, py;   // image the bench intends to load
    img_t mx, my;   // evaluator point memory, as written by the DUT
    int   n_vec = 0, n_err = 0, n_acks = 0, n_done = 0, lat = 0;
    bit   stall = 1'b0;

    function automatic int cov(input img_t ax, input img_t ay, input int cx, input int cy,
                               input int ox, input int oy);
        int n = 0;
        for (int i = 0; i < NPTS; i++) begin
            if ((ax[i]-cx)*(ax[i]-cx) + (ay[i]-cy)*(ay[i]-cy) <= R2 ||
                (ax[i]-ox)*(ax[i]-ox) + (ay[i]-oy)*(ay[i]-oy) <= R2) n++;
        end
        return n;
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > 15) ? 15 : v;
    endfunction

    // Behavioural evaluator (3-cycle ack latency) plus point memory and DONE counter.
    always @(posedge CLK) begin
        if (bus.PT_WE === 1'b1 && RST === 1'b1 && int'(bus.PT_ADDR) < NPTS) begin
            mx[bus.PT_ADDR] = int'(bus.PT_X);
            my[bus.PT_ADDR] = int'(bus.PT_Y);
        end
        if (bus.EV_REQ === 1'b1 && bus.EV_ACK === 1'b1) n_acks++;
        if (DONE === 1'b1) n_done++;
        #1;
        if (bus.EV_ACK === 1'b1) begin
            bus.EV_ACK = 1'b0;
            lat = 0;
        end else if (bus.EV_REQ === 1'b1 && !stall) begin
            lat++;
            if (lat == 3) begin
                bus.EV_CNT = 6'(cov(mx, my, int'(bus.EV_CX), int'(bus.EV_CY),
                                    int'(bus.EV_OX), int'(bus.EV_OY)));
                bus.EV_ACK = 1'b1;
            end
        end else if (bus.EV_REQ !== 1'b1) begin
            lat = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference search straight from the scan rules: best count strictly
    // improves, ties keep the earliest candidate, y-major order.
    task automatic ref_search(input img_t ax, input img_t ay, output int e1x, output int e1y,
                              output int e2x, output int e2y, output int eacks);
        int  best, pos, cnt, npass;
        bit  imp, found, fin;
        best = 0; pos = 0; npass = 0; eacks = 0; fin = 1'b0;
        e1x = 0; e1y = 0; e2x = INIT_X; e2y = INIT_Y;
        while (!fin) begin
            imp = 1'b0;
            for (int s = 0; s < 2 && !fin; s++) begin
                found = 1'b0;
                for (int k = 0; k < 256; k++) begin
                    cnt = (s == 0) ? cov(ax, ay, k % 16, k / 16, e2x, e2y)
                                   : cov(ax, ay, k % 16, k / 16, e1x, e1y);
                    eacks++;
                    if (FULL && cnt == NPTS) begin
                        pos = k; found = 1'b1; fin = 1'b1;
                        break;
                    end
                    if (cnt > best) begin
                        best = cnt; pos = k; found = 1'b1; imp = 1'b1;
                    end
                end
                if (found) begin
                    if (s == 0) begin e1x = pos % 16; e1y = pos / 16; end
                    else        begin e2x = pos % 16; e2y = pos / 16; end
                end
            end
            npass++;
            if (!fin && (!imp || npass == MAX_PASS)) fin = 1'b1;
        end
    endtask

    task automatic img_fill(input int ax, input int ay, input int bx, input int by);
        for (int i = 0; i < NPTS; i++) begin
            px[i] = (i < NPTS / 2) ? ax : bx;
            py[i] = (i < NPTS / 2) ? ay : by;
        end
    endtask

    task automatic img_rand();
        int cx[3], cy[3];
        for (int k = 0; k < 3; k++) begin
            cx[k] = int'($urandom_range(15, 0));
            cy[k] = int'($urandom_range(15, 0));
        end
        for (int i = 0; i < NPTS; i++) begin
            px[i] = clamp(cx[i % 3] + int'($urandom_range(4, 0)) - 2);
            py[i] = clamp(cy[i % 3] + int'($urandom_range(4, 0)) - 2);
        end
    endtask

    // Called just after an edge; the next edge takes point 0.
    task automatic load_image();
        int          bad_addr = 0, bad_done = 0, bad_c = 0;
        logic [15:0] c_snap;
        c_snap = {C1X, C1Y, C2X, C2Y};
        n_acks = 0;
        for (int i = 0; i < NPTS; i++) begin
            X = 4'(px[i]);
            Y = 4'(py[i]);
            @(negedge CLK);
            if (bus.PT_WE !== 1'b1 || bus.PT_ADDR !== 6'(i)) bad_addr++;
            if (DONE !== 1'b0) bad_done++;
            if ({C1X, C1Y, C2X, C2Y} !== c_snap) bad_c++;
            @(posedge CLK); #1;
        end
        chk("load_addr_seq", bad_addr, 0);
        chk("load_done_low", bad_done, 0);
        chk("load_c_held", bad_c, 0);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if (DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic finish_image(input string tag, input int exp_done);
        int          e1x, e1y, e2x, e2y, ea;
        bit          ok;
        logic [15:0] exp_c;
        ref_search(px, py, e1x, e1y, e2x, e2y, ea);
        exp_c = {4'(e1x), 4'(e1y), 4'(e2x), 4'(e2y)};
        wait_done(ok);
        chk({tag, "_done_seen"}, 32'(ok), 1);
        chk({tag, "_centres"}, {C1X, C1Y, C2X, C2Y}, exp_c);
        chk({tag, "_acks"}, n_acks, ea);
        @(posedge CLK); #1;
        chk({tag, "_done_pulse"}, {DONE, bus.PT_WE, bus.PT_ADDR}, {1'b0, 1'b1, 6'd0});
        chk({tag, "_c_held"}, {C1X, C1Y, C2X, C2Y}, exp_c);
        chk({tag, "_done_count"}, n_done, exp_done);
    endtask

    initial begin
        logic [16:0] snap;
        logic [15:0] csnap;
        int          bad;
        bus.EV_ACK = 1'b0;
        bus.EV_CNT = '0;
        RST = 1'b0;
        repeat (3) @(posedge CLK); #1;
        chk("rst_req_done", {bus.EV_REQ, DONE}, 0);
        chk("rst_c", {C1X, C1Y, C2X, C2Y}, 0);
        chk("rst_ops", {bus.EV_CX, bus.EV_CY, bus.EV_OX, bus.EV_OY}, 0);
        chk("rst_load", {bus.PT_WE, bus.PT_ADDR}, {1'b1, 6'd0});
        RST = 1'b1;

        // Image A: all points at (3,3).
        img_fill(3, 3, 3, 3);
        load_image();
        chk("A_first_req", {bus.EV_REQ, bus.EV_CX, bus.EV_CY, bus.EV_OX, bus.EV_OY},
            {1'b1, 4'd0, 4'd0, 4'(INIT_X), 4'(INIT_Y)});
        finish_image("A", 1);
        chk("A_spec_c", {C1X, C1Y, C2X, C2Y}, 16'h1088);

        // Image B back-to-back, with a 100-cycle evaluator stall in SCAN1.
        img_fill(2, 2, 12, 12);
        load_image();
        repeat (300) @(posedge CLK); #1;
        stall = 1'b1;
        repeat (2) @(posedge CLK); #1;
        snap  = {bus.EV_REQ, bus.EV_CX, bus.EV_CY, bus.EV_OX, bus.EV_OY};
        csnap = {C1X, C1Y, C2X, C2Y};
        bad   = 0;
        repeat (100) begin
            @(posedge CLK); #1;
            if ({bus.EV_REQ, bus.EV_CX, bus.EV_CY, bus.EV_OX, bus.EV_OY} !== snap ||
                {C1X, C1Y, C2X, C2Y} !== csnap || DONE !== 1'b0) bad++;
        end
        chk("stall_req_high", bus.EV_REQ, 1);
        chk("stall_stable", bad, 0);
        stall = 1'b0;
        finish_image("B", 2);
        chk("B_spec_c", {C1X, C1Y, C2X, C2Y}, 16'h00C8);

        // Two random clustered images back-to-back.
        img_rand();
        load_image();
        finish_image("C", 3);
        img_rand();
        load_image();
        finish_image("D", 4);

        // Reset pulse during SCAN2, then a fresh load.
        img_fill(2, 2, 12, 12);
        load_image();
        repeat (1100) @(posedge CLK); #1;
        chk("E_pre_rst_c2", {C2X, C2Y}, {4'(INIT_X), 4'(INIT_Y)});
        chk("E_pre_rst_req", bus.EV_REQ, 1);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("E_rst_req_done", {bus.EV_REQ, DONE}, 0);
        chk("E_rst_c", {C1X, C1Y, C2X, C2Y}, 0);
        chk("E_rst_load", {bus.PT_WE, bus.PT_ADDR}, {1'b1, 6'd0});
        RST = 1'b1;
        img_fill(3, 3, 3, 3);
        load_image();
        finish_image("F", 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
